id_stage_pipe: RTL and testbench

Parametrised instruction-decode stage for the MUSA core: it decodes the fetched instruction, reads an internal register file, sign-extends the immediate and registers everything into an ID/EX pipeline register. Unlike the first-generation decode stage, it has valid/ready handshakes on both sides, flush support and load-use hazard detection with bubble insertion. It has a registered write-back port and a saturating stall counter. It sits between the IF stage and the EX stage.

---
 rtl/id_stage_pipe_pkg.sv | 66 ++++++
 rtl/id_stage_pipe_regfile.sv | 41 ++++
 rtl/id_stage_pipe.sv | 134 +++++++++++++
 tb/tb_id_stage_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pipe_pkg.sv
// Purpose: shared decode constants, control bundle and opcode helpers for the MUSA ID/EX path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  // Control bundle handed to EX alongside the operands.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic       jump;
  } ctrl_t;

  // Which instruction field names the destination register.
  typedef enum logic [1:0] {
    DEST_NONE,
    DEST_RD,
    DEST_RT
  } dest_sel_e;

  // Unknown opcodes fall through to an all-zero bundle.
  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    c.alu_op = ALU_ADD;
    case (op)
      OP_RTYPE: begin c.alu_op = ALU_FUNCT; c.reg_write = 1'b1; end
      OP_ADDI:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; end
      OP_LW:    begin c.alu_src = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      OP_SW:    begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
      OP_BEQ:   begin c.alu_op = ALU_SUB; c.branch = 1'b1; end
      OP_J:     c.jump = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  // rt is a true source operand only for these formats.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

  function automatic dest_sel_e dest_sel(input logic [5:0] op);
    case (op)
      OP_RTYPE:      return DEST_RD;
      OP_ADDI, OP_LW: return DEST_RT;
      default:       return DEST_NONE;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_pipe_regfile.sv
// Purpose: NREG x XLEN register file, two combinational read ports, one write port, r0 hardwired to 0.
// Latency: reads 0 cycles, writes land at the clock edge.
// Backpressure: none; optional write-to-read bypass under ID_BYPASS_EN.
module regfile_param #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr0,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata0,
  output logic [XLEN-1:0] rdata1
);

  logic [XLEN-1:0] mem [NREG];

  // Storage: cleared on reset, writes to index 0 dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  // Read ports; with bypass a same-cycle write is visible to the reader.
  always_comb begin
    rdata0 = (raddr0 == '0) ? '0 : mem[raddr0];
    rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
`ifdef ID_BYPASS_EN
    if (we && waddr != '0 && waddr == raddr0) rdata0 = wdata;
    if (we && waddr != '0 && waddr == raddr1) rdata1 = wdata;
`endif
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Purpose: MUSA instruction decode; regfile read, imm sign-extend, load-use bubble, ID/EX register (option ID_BYPASS_EN).
// Latency: 1 cycle from accept to ex_* outputs.
// Backpressure: id_ready drops on ex stall, load-use hazard or flush; ID/EX holds while ex_ready=0.
module id_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int IMM_W = 16,
  parameter int CNT_W = 16,
  localparam int AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [XLEN-1:0]  if_pc,
  output logic             id_ready,
  input  logic             ex_ready,
  input  logic             flush,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs_data,
  output logic [XLEN-1:0]  ex_rt_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [AW-1:0]    ex_rs,
  output logic [AW-1:0]    ex_rt,
  output logic [AW-1:0]    ex_dest,
  output logic [25:0]      ex_jump_target,
  output logic [1:0]       ex_alu_op,
  output logic             ex_alu_src,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_reg_write,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic [CNT_W-1:0] stall_cnt
);
  import id_pkg::*;

  logic [5:0]      op;
  logic [AW-1:0]   rs, rt, rd, dest;
  logic [XLEN-1:0] imm_ext, rs_data, rt_data;
  ctrl_t           ctrl, ex_ctrl;
  logic            hazard, advance, accept;

  assign op      = if_instr[31:26];
  assign rs      = if_instr[21 +: AW];
  assign rt      = if_instr[16 +: AW];
  assign rd      = if_instr[11 +: AW];
  assign imm_ext = {{(XLEN-IMM_W){if_instr[IMM_W-1]}}, if_instr[IMM_W-1:0]};
  assign ctrl    = decode_ctrl(op);

  regfile_param #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rf (
    .clk    (clk),
    .rst_n  (rst),
    .we     (wb_we),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr0 (rs),
    .raddr1 (rt),
    .rdata0 (rs_data),
    .rdata1 (rt_data)
  );

  // Resolve the destination index; non-writing instructions carry 0.
  always_comb begin
    dest = '0;
    case (dest_sel(op))
      DEST_RD: dest = rd;
      DEST_RT: dest = rt;
      default: dest = '0;
    endcase
  end

  // A load in EX whose result feeds this instruction forces one bubble.
  assign hazard   = ex_valid && ex_ctrl.mem_read && (ex_dest != '0) &&
                    ((ex_dest == rs) || (uses_rt(op) && (ex_dest == rt)));
  assign advance  = !ex_valid || ex_ready;
  assign id_ready = advance && !hazard && !flush;
  assign accept   = if_valid && id_ready;

  // ID/EX register: flush kills, accept loads, otherwise bubble on advance or hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      ex_rs_data     <= '0;
      ex_rt_data     <= '0;
      ex_imm         <= '0;
      ex_rs          <= '0;
      ex_rt          <= '0;
      ex_dest        <= '0;
      ex_jump_target <= '0;
      ex_ctrl        <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (advance) begin
      ex_valid <= accept;
      if (accept) begin
        ex_pc          <= if_pc;
        ex_rs_data     <= rs_data;
        ex_rt_data     <= rt_data;
        ex_imm         <= imm_ext;
        ex_rs          <= rs;
        ex_rt          <= rt;
        ex_dest        <= dest;
        ex_jump_target <= if_instr[25:0];
        ex_ctrl        <= ctrl;
      end
    end
  end

  // Count bubbles actually inserted for a waiting instruction; sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (if_valid && hazard && advance && !flush && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign ex_alu_op     = ex_ctrl.alu_op;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_branch     = ex_ctrl.branch;
  assign ex_jump       = ex_ctrl.jump;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Purpose: self-checking bench for id_stage_pipe against a transaction-level model (honours ID_BYPASS_EN).
// Latency: one model step per clock; outputs sampled 1 time unit after the rising edge.
// Backpressure: ex_ready/flush randomised plus directed stall, flush and hazard sequences.
module tb_id_stage_pipe;
  localparam int XLEN = 32, NREG = 32, AW = 5, IMM_W = 16, CNT_W = 4;
  localparam int SAT = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst = 1'b0;
  logic if_valid = 1'b0, ex_ready = 1'b0, flush = 1'b0, wb_we = 1'b0;
  logic [31:0] if_instr = '0, if_pc = '0, wb_data = '0;
  logic [AW-1:0] wb_addr = '0;
  logic id_ready, ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [AW-1:0] ex_rs, ex_rt, ex_dest;
  logic [25:0] ex_jump_target;
  logic [1:0] ex_alu_op;
  logic ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_branch, ex_jump;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(XLEN), .NREG(NREG), .IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_jump_target(ex_jump_target), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .stall_cnt(stall_cnt)
  );

  // Architectural view of what EX should be holding.
  typedef struct {
    bit        valid;
    bit [31:0] pc, rs_data, rt_data, imm;
    bit [4:0]  rs, rt, dest;
    bit [25:0] jt;
    bit [1:0]  alu_op;
    bit        alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, jump;
  } ex_t;

  ex_t       m_ex;
  bit [31:0] m_rf [NREG];
  int        m_cnt;
  int        checks = 0, failures = 0;
  logic [31:0] pc_ctr = 32'h100;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [31:0] rd_reg(input bit [4:0] a);
    if (a == 0) return 32'h0;
`ifdef ID_BYPASS_EN
    if (wb_we && wb_addr == a) return wb_data;
`endif
    return m_rf[a];
  endfunction

  // Instruction semantics straight from the opcode table.
  function automatic ex_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
    ex_t e = '{default: 0};
    e.valid = 1; e.pc = pc; e.rs = ins[25:21]; e.rt = ins[20:16];
    e.rs_data = rd_reg(e.rs); e.rt_data = rd_reg(e.rt);
    e.imm = {{16{ins[15]}}, ins[15:0]}; e.jt = ins[25:0];
    case (ins[31:26])
      6'h00: begin e.alu_op = 2; e.reg_write = 1; e.dest = ins[15:11]; end
      6'h08: begin e.alu_src = 1; e.reg_write = 1; e.dest = ins[20:16]; end
      6'h23: begin e.alu_src = 1; e.mem_read = 1; e.mem_to_reg = 1; e.reg_write = 1; e.dest = ins[20:16]; end
      6'h2B: begin e.alu_src = 1; e.mem_write = 1; end
      6'h04: begin e.alu_op = 1; e.branch = 1; end
      6'h02: e.jump = 1;
      default: ;
    endcase
    return e;
  endfunction

  // Does the offered instruction consume the register a load in EX is producing?
  function automatic bit model_hazard(input logic [31:0] ins);
    bit reads_rt;
    reads_rt = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h2B) || (ins[31:26] == 6'h04);
    if (!(m_ex.valid && m_ex.mem_read) || m_ex.dest == 0) return 0;
    return (m_ex.dest == ins[25:21]) || (reads_rt && m_ex.dest == ins[20:16]);
  endfunction

  task automatic model_reset();
    m_ex = '{default: 0};
    foreach (m_rf[i]) m_rf[i] = 0;
    m_cnt = 0;
  endtask

  task automatic check_outputs();
    check("ex_valid", ex_valid, m_ex.valid);
    check("ex_pc", ex_pc, m_ex.pc);
    check("ex_rs_data", ex_rs_data, m_ex.rs_data);
    check("ex_rt_data", ex_rt_data, m_ex.rt_data);
    check("ex_imm", ex_imm, m_ex.imm);
    check("ex_rs", ex_rs, m_ex.rs);
    check("ex_rt", ex_rt, m_ex.rt);
    check("ex_dest", ex_dest, m_ex.dest);
    check("ex_jump_target", ex_jump_target, m_ex.jt);
    check("ex_alu_op", ex_alu_op, m_ex.alu_op);
    check("ex_ctrl", {ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_branch, ex_jump},
          {m_ex.alu_src, m_ex.mem_read, m_ex.mem_write, m_ex.mem_to_reg, m_ex.reg_write, m_ex.branch, m_ex.jump});
    check("stall_cnt", stall_cnt, m_cnt);
  endtask

  // One clock: check id_ready mid-cycle, advance the model, check registered outputs after the edge.
  task automatic step();
    bit hz, adv, rdy;
    ex_t nx;
    @(negedge clk);
    hz  = model_hazard(if_instr);
    adv = !m_ex.valid || ex_ready;
    rdy = adv && !hz && !flush;
    check("id_ready", id_ready, rdy);
    nx = m_ex;
    if (flush) nx.valid = 0;
    else if (adv && if_valid && rdy) nx = model_decode(if_instr, if_pc);
    else if (adv) nx.valid = 0;
    if (if_valid && hz && adv && !flush && m_cnt < SAT) m_cnt++;
    if (wb_we && wb_addr != 0) m_rf[wb_addr] = wb_data;
    @(posedge clk);
    #1;
    m_ex = nx;
    check_outputs();
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input bit er, input bit fl,
                       input bit we, input logic [4:0] wa, input logic [31:0] wd);
    if_valid = v; if_instr = ins; if_pc = pc_ctr; pc_ctr += 4;
    ex_ready = er; flush = fl; wb_we = we; wb_addr = wa; wb_data = wd;
    step();
  endtask

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 11'h020};
  endfunction

  task automatic random_cycles(input int n);
    logic [5:0] op;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 6))
        0: op = 6'h00; 1: op = 6'h08; 2: op = 6'h23; 3: op = 6'h2B;
        4: op = 6'h04; 5: op = 6'h02; default: op = 6'($urandom_range(0, 63));
      endcase
      drive($urandom_range(0, 9) < 8,
            {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 11'($urandom)},
            $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check("rst_id_ready", id_ready, 1'b1);
    rst = 1'b1;

    // Write-back then an ADDI that reads it.
    drive(0, 32'h0, 1, 0, 1, 5'd5, 32'h1234);
    drive(1, mk_i(6'h08, 5'd5, 5'd6, 16'hFFFE), 1, 0, 0, 5'd0, 32'h0);
    check("addi_rs_data", ex_rs_data, 32'h1234);
    check("addi_imm", ex_imm, 32'hFFFF_FFFE);
    check("addi_dest", ex_dest, 5'd6);
    check("addi_ctrl", {ex_alu_src, ex_reg_write}, 2'b11);

    // Load-use: exactly one bubble, then accept.
    drive(1, mk_i(6'h23, 5'd0, 5'd3, 16'h0004), 1, 0, 0, 5'd0, 32'h0);
    drive(1, mk_r(5'd3, 5'd1, 5'd2), 1, 0, 0, 5'd0, 32'h0);
    check("bubble_valid", ex_valid, 1'b0);
    drive(1, mk_r(5'd3, 5'd1, 5'd2), 1, 0, 0, 5'd0, 32'h0);
    check("dep_accepted", ex_valid, 1'b1);
    check("dep_rs", ex_rs, 5'd3);
    check("stall_one", stall_cnt, 4'd1);

    // EX stalled with a load and a dependent waiting: nothing moves, nothing counted.
    drive(1, mk_i(6'h23, 5'd0, 5'd4, 16'h0008), 1, 0, 0, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1, mk_r(5'd4, 5'd4, 5'd1), 0, 0, 0, 5'd0, 32'h0);
      check("hold_dest", ex_dest, 5'd4);
      check("hold_cnt", stall_cnt, 4'd1);
    end

    // Flush with a live hazard wins and is not a counted bubble.
    drive(1, mk_r(5'd4, 5'd4, 5'd1), 1, 1, 0, 5'd0, 32'h0);
    check("flush_valid", ex_valid, 1'b0);
    check("flush_cnt", stall_cnt, 4'd1);

    // r0 ignores writes.
    drive(0, 32'h0, 1, 0, 1, 5'd0, 32'hFFFF);
    drive(1, mk_i(6'h08, 5'd0, 5'd9, 16'h0001), 1, 0, 0, 5'd0, 32'h0);
    check("r0_read", ex_rs_data, 32'h0);

    // Write and read of r7 in the same cycle.
    drive(0, 32'h0, 1, 0, 1, 5'd7, 32'h55);
    drive(1, mk_i(6'h08, 5'd7, 5'd8, 16'h0002), 1, 0, 1, 5'd7, 32'hAA);
`ifdef ID_BYPASS_EN
    check("same_cycle_r7", ex_rs_data, 32'hAA);
`else
    check("same_cycle_r7", ex_rs_data, 32'h55);
`endif
    drive(1, mk_i(6'h08, 5'd7, 5'd8, 16'h0003), 1, 0, 0, 5'd0, 32'h0);
    check("later_r7", ex_rs_data, 32'hAA);

    // 2^CNT_W+5 bubbles saturate the counter.
    for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
      drive(1, mk_i(6'h23, 5'd0, 5'd9, 16'h0000), 1, 0, 0, 5'd0, 32'h0);
      drive(1, mk_r(5'd9, 5'd2, 5'd3), 1, 0, 0, 5'd0, 32'h0);
      drive(1, mk_r(5'd9, 5'd2, 5'd3), 1, 0, 0, 5'd0, 32'h0);
    end
    check("stall_sat", stall_cnt, 4'hF);

    random_cycles(400);

    // Asynchronous reset with a live instruction in EX.
    drive(1, mk_i(6'h08, 5'd1, 5'd2, 16'h0010), 1, 0, 0, 5'd0, 32'h0);
    if_valid = 0; wb_we = 0; flush = 0; ex_ready = 1;
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", ex_valid, 1'b0);
    check("async_rst_cnt", stall_cnt, 4'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();

    random_cycles(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
